// File: rtl/inst_encode_loader.sv
// Instruction encoder and program loader: packs field tuples into 32-bit
// instruction words and streams legal ones into instruction memory.
module inst_encode_loader #(
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MEM_AW-1:0] base_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opcode,
    input  logic [4:0]        in_r0,
    input  logic [4:0]        in_r1,
    input  logic [4:0]        in_r2,
    input  logic [15:0]       in_addr,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [MEM_AW:0]   inst_count,
    output logic [7:0]        err_count
);

    // state  | meaning
    // IDLE   | waiting for start
    // RUN    | accepting tuples
    // WRITE  | holding a memory write until mem_ack
    // DONE   | session ended by finish
    // FULL   | memory exhausted
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_WRITE, S_DONE, S_FULL} state_t;

    state_t              state_q, state_d;
    logic [MEM_AW-1:0]   ptr_q, ptr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [MEM_AW:0]     cnt_q, cnt_d;
    logic [7:0]          errc_q, errc_d;
    logic                err_q, err_d;
    logic                fin_q, fin_d;

    logic [31:0]         enc_word;
    logic                enc_legal;
    logic [MEM_AW:0]     cnt_inc;

    always_comb begin
        enc_word        = '0;
        enc_legal       = 1'b1;
        enc_word[31:29] = in_opcode;
        enc_word[28:24] = in_r0;
        case (in_opcode)
            3'b000, 3'b001: begin
                enc_word[15:0] = in_addr;
            end
            3'b010, 3'b011: begin
                enc_word[23:19] = in_r1;
                enc_word[14:0]  = in_addr[14:0];
                enc_legal       = ~in_addr[15];
            end
            3'b111: begin
                enc_word[18:14] = in_r2;
                enc_word[13:0]  = in_addr[13:0];
                enc_legal       = (in_addr[15:14] == 2'b00);
            end
            default: begin
                enc_word[23:19] = in_r1;
                enc_word[18:14] = in_r2;
                enc_word[13:0]  = in_addr[13:0];
                enc_legal       = (in_addr[15:14] == 2'b00);
            end
        endcase
    end

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        errc_d  = errc_q;
        err_d   = 1'b0;
        fin_d   = fin_q;
        if (start) begin
            state_d = S_RUN;
            ptr_d   = base_addr;
            cnt_d   = '0;
            errc_d  = '0;
            fin_d   = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (in_valid) begin
                        fin_d = fin_q | finish;
                        if (enc_legal) begin
                            wdata_d = enc_word;
                            state_d = S_WRITE;
                        end else begin
                            err_d = 1'b1;
                            if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
                        end
                    end else if (finish || fin_q) begin
                        state_d = S_DONE;
                        fin_d   = 1'b0;
                    end
                end
                S_WRITE: begin
                    fin_d = fin_q | finish;
                    if (mem_ack) begin
                        cnt_d = cnt_inc;
                        ptr_d = ptr_q + 1'b1;
                        // finish wins over FULL so the session reports DONE
                        if (fin_q || finish) begin
                            state_d = S_DONE;
                            fin_d   = 1'b0;
                        end else if ((&ptr_q) || cnt_inc == {1'b1, {MEM_AW{1'b0}}}) begin
                            state_d = S_FULL;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            errc_q  <= '0;
            err_q   <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            errc_q  <= errc_d;
            err_q   <= err_d;
            fin_q   <= fin_d;
        end
    end

    assign in_ready   = (state_q == S_RUN);
    assign mem_we     = (state_q == S_WRITE);
    assign mem_addr   = ptr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = (state_q == S_RUN) || (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign full       = (state_q == S_FULL);
    assign err        = err_q;
    assign inst_count = cnt_q;
    assign err_count  = errc_q;

endmodule

// File: tb/tb_inst_encode_loader.sv
// Bench for inst_encode_loader: directed test-plan steps followed by random
// tuples, all checked against an arithmetic encoding model.
module tb_inst_encode_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic        finish = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_opcode = '0;
    logic [4:0]  in_r0 = '0, in_r1 = '0, in_r2 = '0;
    logic [15:0] in_addr = '0;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        busy, done, full, err;
    logic [8:0]  inst_count;
    logic [7:0]  err_count;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  exp_ptr;
    int          exp_cnt;
    int          exp_err;
    bit          fin_pend;

    inst_encode_loader #(.MEM_AW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_r0(in_r0), .in_r1(in_r1), .in_r2(in_r2),
        .in_addr(in_addr), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .busy(busy), .done(done),
        .full(full), .err(err), .inst_count(inst_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int unsigned op, input int unsigned r0,
                                               input int unsigned r1, input int unsigned r2,
                                               input int unsigned ad);
        logic [31:0] w;
        w = (op << 29) | (r0 << 24);
        if (op < 2)      w = w | ad;
        else if (op < 4) w = w | (r1 << 19) | (ad % 32768);
        else if (op < 7) w = w | (r1 << 19) | (r2 << 14) | (ad % 16384);
        else             w = w | (r2 << 14) | (ad % 16384);
        return w;
    endfunction

    function automatic bit model_legal(input int unsigned op, input int unsigned ad);
        if (op < 2) return 1'b1;
        if (op < 4) return ad < 32768;
        return ad < 16384;
    endfunction

    task automatic do_start(input int unsigned base);
        base_addr = base[7:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_ptr = base[7:0]; exp_cnt = 0; exp_err = 0; fin_pend = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_ready", {31'd0, in_ready}, 32'd1);
        chk("start_cnt", {23'd0, inst_count}, 32'd0);
        chk("start_errcnt", {24'd0, err_count}, 32'd0);
        chk("start_ptr", {24'd0, mem_addr}, {24'd0, exp_ptr});
        chk("start_done", {30'd0, done, full}, 32'd0);
    endtask

    task automatic send(input int unsigned op, input int unsigned r0, input int unsigned r1,
                        input int unsigned r2, input int unsigned ad, input int dly,
                        input int fin_at);
        logic [31:0] w;
        bit          lg, wrap;
        w  = model_word(op, r0, r1, r2, ad);
        lg = model_legal(op, ad);
        chk("ready_before", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_opcode = op[2:0]; in_r0 = r0[4:0]; in_r1 = r1[4:0]; in_r2 = r2[4:0];
        in_addr = ad[15:0];
        tick();
        in_valid = 1'b0;
        if (!lg) begin
            if (exp_err < 255) exp_err++;
            chk("rej_err", {31'd0, err}, 32'd1);
            chk("rej_we", {31'd0, mem_we}, 32'd0);
            chk("rej_ready", {31'd0, in_ready}, 32'd1);
            chk("rej_errcnt", {24'd0, err_count}, exp_err);
            tick();
            chk("rej_err_clr", {31'd0, err}, 32'd0);
        end else begin
            chk("wr_we", {31'd0, mem_we}, 32'd1);
            chk("wr_addr", {24'd0, mem_addr}, {24'd0, exp_ptr});
            chk("wr_data", mem_wdata, w);
            chk("wr_ready", {31'd0, in_ready}, 32'd0);
            for (int i = 0; i < dly; i++) begin
                finish = (i == fin_at);
                if (i == fin_at) fin_pend = 1'b1;
                tick();
                finish = 1'b0;
                chk("hold_we", {31'd0, mem_we}, 32'd1);
                chk("hold_addr", {24'd0, mem_addr}, {24'd0, exp_ptr});
                chk("hold_data", mem_wdata, w);
                chk("hold_ready", {31'd0, in_ready}, 32'd0);
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            wrap = (exp_ptr == 8'hFF);
            exp_ptr = exp_ptr + 8'd1;
            exp_cnt++;
            chk("ack_cnt", {23'd0, inst_count}, exp_cnt);
            chk("ack_we", {31'd0, mem_we}, 32'd0);
            if (fin_pend) begin
                fin_pend = 1'b0;
                chk("ack_done", {31'd0, done}, 32'd1);
                chk("ack_busy", {31'd0, busy}, 32'd0);
            end else if (wrap || exp_cnt == 256) begin
                chk("ack_full", {31'd0, full}, 32'd1);
                chk("ack_full_rdy", {31'd0, in_ready}, 32'd0);
            end else begin
                chk("ack_ready", {31'd0, in_ready}, 32'd1);
            end
        end
    endtask

    initial begin
        tick();
        chk("rst_outs", {24'd0, in_ready, mem_we, busy, done, full, err, 2'b00}, 32'd0);
        chk("rst_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_cnt", {23'd0, inst_count}, 32'd0);
        chk("rst_errcnt", {24'd0, err_count}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", {31'd0, in_ready}, 32'd0);

        // single tuple, immediate ack
        do_start(32'h10);
        send(3'b010, 3, 5, 0, 16'h1234, 0, -1);
        chk("tp1_cnt", {23'd0, inst_count}, 32'd1);

        // back-to-back tuples
        send(3'b000, 31, 0, 0, 16'hBEEF, 0, -1);
        send(3'b101, 1, 2, 3, 16'h0ABC, 0, -1);
        send(3'b111, 0, 0, 31, 16'h3FFF, 0, -1);

        // rejected tuple
        send(3'b100, 0, 0, 0, 16'h4000, 0, -1);
        chk("rej_cnt_total", {24'd0, err_count}, 32'd1);

        // delayed ack with finish during the wait
        send(3'b011, 7, 9, 0, 16'h7FFF, 3, 1);
        chk("fin_done", {31'd0, done}, 32'd1);

        // fill to top of memory
        do_start(32'hFE);
        send(3'b001, 1, 0, 0, 16'h0001, 0, -1);
        send(3'b001, 2, 0, 0, 16'h0002, 1, -1);
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("full_no_we", {31'd0, mem_we}, 32'd0);
        chk("full_hold", {31'd0, full}, 32'd1);
        chk("full_cnt", {23'd0, inst_count}, 32'd2);

        // start aborts a pending write
        do_start(32'h20);
        in_valid = 1'b1; in_opcode = 3'b000; in_addr = 16'h5555;
        tick();
        in_valid = 1'b0;
        chk("abort_we_on", {31'd0, mem_we}, 32'd1);
        start = 1'b1; base_addr = 8'h20;
        tick();
        start = 1'b0;
        chk("abort_we_off", {31'd0, mem_we}, 32'd0);
        chk("abort_cnt", {23'd0, inst_count}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_ptr", {24'd0, mem_addr}, 32'h20);

        // random tuples
        do_start($urandom_range(0, 8'hB0));
        for (int n = 0; n < 40; n++) begin
            int unsigned op, ad;
            op = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) ad = $urandom_range(0, 65535);
            else                           ad = $urandom_range(0, 16383);
            send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 ad, int'($urandom_range(0, 3)), -1);
        end
        chk("rnd_errcnt", {24'd0, err_count}, exp_err);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        chk("rnd_done", {31'd0, done}, 32'd1);

        // asynchronous reset during a write
        do_start(32'h40);
        in_valid = 1'b1; in_opcode = 3'b001; in_addr = 16'h1111;
        tick();
        in_valid = 1'b0;
        chk("arst_we_on", {31'd0, mem_we}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_we_off", {31'd0, mem_we}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_cnt", {23'd0, inst_count}, 32'd0);
        tick();
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
